// File: rtl/peripheral_mpi_noc_arbiter.sv
// peripheral_mpi_noc_arbiter: packet-atomic round-robin arbiter onto one NoC injection port.
// Optional stall watchdog enabled by defining PERIPHERAL_MPI_ARB_WATCHDOG_EN.
module peripheral_mpi_noc_arbiter #(
  parameter int NOC_FLIT_WIDTH = 32,
  parameter int CHANNELS = 4,
  parameter int MAX_STALL = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CHANNELS*NOC_FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]                in_last,
  input  logic [CHANNELS-1:0]                in_valid,
  output logic [CHANNELS-1:0]                in_ready,
  output logic [NOC_FLIT_WIDTH-1:0]          out_flit,
  output logic                               out_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CHANNELS-1:0]                grant,
  output logic                               stall_err
);
  localparam int IW = $clog2(CHANNELS);
  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, owner, owner_n, pick;
  logic [IW-1:0] cand [CHANNELS];
  logic [NOC_FLIT_WIDTH-1:0] flit [CHANNELS];
  logic [CHANNELS-1:0] onehot;
  logic busy, flushing, xfer, stall_hit;
  if (CHANNELS < 2 || CHANNELS > 16 || MAX_STALL < 1) begin : g_cfg_check
    $error("peripheral_mpi_noc_arbiter: CHANNELS must be 2..16 and MAX_STALL >= 1");
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign cand[i] = IW'((int'(ptr) + i + 1) % CHANNELS);
    assign flit[i] = in_flit[i*NOC_FLIT_WIDTH +: NOC_FLIT_WIDTH];
  end
  // Walk from farthest to nearest candidate so the nearest valid requester wins.
  always_comb begin
    pick = ptr;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (in_valid[cand[i]]) pick = cand[i];
  end
  assign onehot = CHANNELS'(1) << owner;
  assign busy = rst && state == BUSY;
  assign flushing = rst && state == FLUSH;
  assign xfer = in_valid[owner] && out_ready;
  assign grant = (busy || flushing) ? onehot : '0;
  assign out_valid = flushing || (busy && in_valid[owner]);
  assign out_last = flushing || (busy && in_last[owner]);
  assign out_flit = busy ? flit[owner] : '0;
  assign in_ready = (busy && out_ready) ? onehot : '0;
`ifdef PERIPHERAL_MPI_ARB_WATCHDOG_EN
  localparam int CW = MAX_STALL > 255 ? $clog2(MAX_STALL + 1) : 8;
  logic [CW-1:0] cnt;
  logic err;
  assign stall_hit = busy && !in_valid[owner] && cnt == CW'(MAX_STALL - 1);
  assign stall_err = err;
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (state != BUSY || xfer) ? '0 : (in_valid[owner] ? cnt : cnt + 1'b1);
      if (stall_hit) err <= 1'b1;
    end
  end
`else
  assign stall_hit = 1'b0;
  assign stall_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= IW'(CHANNELS - 1);
      owner <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      owner <= owner_n;
    end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    owner_n = owner;
    case (state)
      IDLE: if (|in_valid) begin
        state_n = BUSY;
        owner_n = pick;
      end
      BUSY: if (stall_hit) state_n = FLUSH;
      else if (xfer && in_last[owner]) begin
        state_n = IDLE;
        ptr_n = owner;
      end
      FLUSH: if (out_ready) begin
        state_n = IDLE;
        ptr_n = owner;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
